// File: rtl/aes_pkg.sv
// Shared constants and type definitions for the AES-128 iterative round sequencer.
package aes_pkg;

  // Number of cipher rounds after the initial AddRoundKey and the block width.
  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  // Direction encodings carried on the mode inputs and outputs.
  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  // Sequencer phases: wait for a block, whiten it, run the rounds, hand the result over.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// Up/down round index counter. Encrypt counts 0 -> NR, decrypt counts NR -> 0.
// The step request is ignored once the terminal round is reached, so the index
// can never leave 0..NR whatever the caller does.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       load_mode,
  input  logic       step,
  output logic [3:0] round,
  output logic       is_last
);

  localparam logic [3:0] LAST_UP = 4'(NR);

  logic       dir_q;
  logic [3:0] round_q;

  // Load the start index and direction on accept, otherwise step toward the terminal round.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= 4'd0;
      dir_q   <= AES_ENC;
    end else if (load) begin
      dir_q   <= load_mode;
      round_q <= (load_mode == AES_DEC) ? LAST_UP : 4'd0;
    end else if (step && !is_last) begin
      round_q <= (dir_q == AES_DEC) ? (round_q - 4'd1) : (round_q + 4'd1);
    end
  end

  assign is_last = (dir_q == AES_DEC) ? (round_q == 4'd0) : (round_q == LAST_UP);
  assign round   = round_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the AES-128 iterative round datapath: accepts a key/data block,
// drives the round index to the key generator, iterates the state register through
// the external round datapath, and returns the result over a valid/ready handshake.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [AES_BLK_W-1:0] in_key,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [AES_BLK_W-1:0] key_out,
  output logic [3:0]           round,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic                 rnd_mode,
  output logic                 rnd_final,
  input  logic [AES_BLK_W-1:0] rnd_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  aes_ctrl_state_t state_q, state_d;

  logic                 in_ready_q;
  logic                 accept;
  logic                 cnt_step;
  logic                 load_white;
  logic                 load_round;
  logic                 is_last;
  logic [AES_BLK_W-1:0] key_q;
  logic [AES_BLK_W-1:0] data_q;
  logic [AES_BLK_W-1:0] blk_q;
  logic                 mode_q;

  aes_round_cnt #(
    .NR(NR)
  ) u_round_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_mode(in_mode),
    .step     (cnt_step),
    .round    (round),
    .is_last  (is_last)
  );

  // Next-state and per-phase control strobes; IDLE is always revisited between blocks.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    cnt_step   = 1'b0;
    load_white = 1'b0;
    load_round = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        load_white = 1'b1;
        cnt_step   = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        load_round = 1'b1;
        if (is_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_step = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus a registered ready flag that mirrors IDLE but stays low while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Block registers: capture the request on accept, whiten in INIT, take one round per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      data_q <= '0;
      mode_q <= AES_ENC;
      blk_q  <= '0;
    end else begin
      if (accept) begin
        key_q  <= in_key;
        data_q <= in_data;
        mode_q <= in_mode;
      end
      if (load_white) begin
        blk_q <= data_q ^ round_key;
      end else if (load_round) begin
        blk_q <= rnd_result;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign key_out   = key_q;
  assign rnd_state = blk_q;
  assign rnd_mode  = mode_q;
  assign rnd_final = (state_q == ST_RUN) && is_last;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = blk_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: emulates the external key generator and round datapath,
// and checks results against a whole-cipher AES-128 reference built from GF(2^8) arithmetic.
module tb_aes_round_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [7:0]   INV_EXP  = 8'hFE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] rnd_state;
  logic         rnd_mode;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int final_cnt = 0;
  int oob_cnt = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_key    (in_key),
    .in_data   (in_data),
    .key_out   (key_out),
    .round     (round),
    .round_key (round_key),
    .rnd_state (rnd_state),
    .rnd_mode  (rnd_mode),
    .rnd_final (rnd_final),
    .rnd_result(rnd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, b;
    r = 8'h01; b = x;
    for (int i = 0; i < 8; i++) begin
      if (INV_EXP[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? inv_sbox(gb(s, i)) : sbox(gb(s, i));
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
        o[127-8*(r+4*c) -: 8] = gb(s, src);
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      if (!inv) begin
        o[127-32*c -: 32] = {gmul(a0,8'd2) ^ gmul(a1,8'd3) ^ a2 ^ a3,
                             a0 ^ gmul(a1,8'd2) ^ gmul(a2,8'd3) ^ a3,
                             a0 ^ a1 ^ gmul(a2,8'd2) ^ gmul(a3,8'd3),
                             gmul(a0,8'd3) ^ a1 ^ a2 ^ gmul(a3,8'd2)};
      end else begin
        o[127-32*c -: 32] = {gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9),
                             gmul(a0,8'd9) ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13),
                             gmul(a0,8'd13) ^ gmul(a1,8'd9) ^ gmul(a2,8'd14) ^ gmul(a3,8'd11),
                             gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9) ^ gmul(a3,8'd14)};
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key_of(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    if (r < 0 || r > 10) return '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk, input bit fin);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!fin) t = mix_cols(t, 1'b0);
    return t ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk, input bit fin);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk;
    if (!fin) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s;
    s = p ^ round_key_of(k, 0);
    for (int r = 1; r <= 10; r++) s = enc_round(s, round_key_of(k, r), r == 10);
    return s;
  endfunction

  function automatic logic [127:0] aes_decrypt(input logic [127:0] k, input logic [127:0] c);
    logic [127:0] s;
    s = c ^ round_key_of(k, 10);
    for (int r = 9; r >= 0; r--) s = dec_round(s, round_key_of(k, r), r == 0);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // External key generator model: round key selected by the driven index.
  always_comb round_key = round_key_of(key_out, int'(round));

  // External round datapath model, including the AddRoundKey step.
  always_comb rnd_result = rnd_mode ? dec_round(rnd_state, round_key, rnd_final)
                                    : enc_round(rnd_state, round_key, rnd_final);

  // Running counts of final-round flags and out-of-range round indices.
  always @(negedge clk) begin
    if (rnd_final) final_cnt <= final_cnt + 1;
    if (round > 4'd10) oob_cnt <= oob_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic m, input logic [127:0] k, input logic [127:0] d,
                           input bit consume, output logic [127:0] res, output int lat,
                           output bit ok);
    int w;
    ok = 1'b1; lat = 0; w = 0; res = '0;
    while (!in_ready && w < 40) begin tick; w++; end
    if (!in_ready) begin
      ok = 1'b0;
    end else begin
      in_valid = 1'b1; in_mode = m; in_key = k; in_data = d;
      tick;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin tick; lat++; end
      if (!out_valid) begin
        ok = 1'b0;
      end else begin
        res = out_data;
        if (consume) begin
          out_ready = 1'b1; tick; out_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick; tick;
    checks++;
    if ({in_ready, out_valid, busy, rnd_final, round, rnd_mode} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0", {in_ready, out_valid, busy, rnd_final, round, rnd_mode});
    end
    checks++;
    if (key_out !== 128'd0) begin errors++; $display("[TB] FAIL reset_key: got %h expected 0", key_out); end
    checks++;
    if ({rnd_state, out_data} !== 256'd0) begin
      errors++; $display("[TB] FAIL reset_data: state %h out %h expected 0", rnd_state, out_data);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release: in_ready %b busy %b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_fips_encrypt;
    logic [127:0] res;
    int lat;
    bit ok;
    run_block(1'b0, FIPS_KEY, FIPS_PT, 1'b1, res, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL fips_enc_timeout: got no result expected one"); end
    checks++;
    if (lat != 12) begin errors++; $display("[TB] FAIL fips_enc_latency: got %0d expected 12", lat); end
    checks++;
    if (res !== FIPS_CT) begin errors++; $display("[TB] FAIL fips_enc_data: got %h expected %h", res, FIPS_CT); end
  endtask

  task automatic test_decrypt;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick; w++; end
    in_valid = 1'b1; in_mode = 1'b1; in_key = FIPS_KEY; in_data = FIPS_CT;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (round !== 4'(11 - k)) begin
        errors++; $display("[TB] FAIL dec_round_seq[%0d]: got %0d expected %0d", k, round, 11 - k);
      end
      checks++;
      if (rnd_final !== (k == 11)) begin
        errors++; $display("[TB] FAIL dec_final[%0d]: got %b expected %b", k, rnd_final, k == 11);
      end
      tick;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== FIPS_PT) begin
      errors++; $display("[TB] FAIL fips_dec_data: valid %b got %h expected %h", out_valid, out_data, FIPS_PT);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [127:0] k, d, exp, res;
    int lat;
    bit ok;
    k = rand128(); d = rand128();
    exp = aes_encrypt(k, d);
    run_block(1'b0, k, d, 1'b0, res, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: got no result expected one"); end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall[%0d]: valid %b ready %b data %h expected 1 0 %h", c, out_valid, in_ready, out_data, exp);
      end
      tick;
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k [3];
    logic [127:0] d [3];
    logic [127:0] got [$];
    logic [127:0] exp;
    int acc_cyc [$];
    int out_cyc [$];
    int idx, busy_acc;
    logic acc;
    idx = 0; busy_acc = 0;
    for (int i = 0; i < 3; i++) begin k[i] = rand128(); d[i] = rand128(); end
    out_ready = 1'b1; in_mode = 1'b0; in_valid = 1'b1; in_key = k[0]; in_data = d[0];
    for (int cyc = 0; cyc < 60 && got.size() < 3; cyc++) begin
      acc = in_valid && in_ready;
      if (acc && busy) busy_acc++;
      if (acc) acc_cyc.push_back(cyc);
      if (out_valid) begin got.push_back(out_data); out_cyc.push_back(cyc); end
      tick;
      if (acc) begin
        idx++;
        if (idx < 3) begin in_key = k[idx]; in_data = d[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got.size() != 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d results expected 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      exp = aes_encrypt(k[i], d[i]);
      checks++;
      if (got[i] !== exp) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got[i], exp); end
    end
    for (int i = 1; i < out_cyc.size(); i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 13) begin
        errors++; $display("[TB] FAIL b2b_out_gap[%0d]: got %0d expected 13", i, out_cyc[i] - out_cyc[i-1]);
      end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 13) begin
        errors++; $display("[TB] FAIL b2b_acc_gap[%0d]: got %0d expected 13", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    checks++;
    if (busy_acc != 0) begin errors++; $display("[TB] FAIL b2b_busy_accept: got %0d expected 0", busy_acc); end
  endtask

  task automatic test_reset_mid_run;
    logic [127:0] k, d, exp, res;
    int lat, seen;
    bit ok;
    k = rand128(); d = rand128();
    in_valid = 1'b1; in_mode = 1'b1; in_key = k; in_data = d;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if (round !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_run_pos: round %0d busy %b expected 5 1", round, busy);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({in_ready, out_valid, busy, rnd_final, round, rnd_mode} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_flags: got %b expected 0", {in_ready, out_valid, busy, rnd_final, round, rnd_mode});
    end
    checks++;
    if ({key_out, rnd_state, out_data} !== 384'd0) begin
      errors++; $display("[TB] FAIL mid_reset_data: key %h state %h out %h expected 0", key_out, rnd_state, out_data);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_release: in_ready %b valid %b expected 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin if (out_valid) seen++; tick; end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL mid_reset_ghost: got %0d valid cycles expected 0", seen); end
    k = rand128(); d = rand128();
    exp = aes_decrypt(k, d);
    run_block(1'b1, k, d, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== exp) begin
      errors++; $display("[TB] FAIL post_reset_dec: ok %b got %h expected %h", ok, res, exp);
    end
  endtask

  task automatic test_key_sweep;
    logic [127:0] k, d, exp, res;
    int lat, f0;
    bit ok;
    for (int n = 0; n < 100; n++) begin
      k = rand128(); d = rand128();
      exp = aes_encrypt(k, d);
      f0 = final_cnt;
      run_block(1'b0, k, d, 1'b1, res, lat, ok);
      checks++;
      if (!ok || res !== exp) begin
        errors++; $display("[TB] FAIL sweep_data[%0d]: ok %b got %h expected %h", n, ok, res, exp);
      end
      checks++;
      if (final_cnt - f0 != 1) begin
        errors++; $display("[TB] FAIL sweep_final[%0d]: got %0d expected 1", n, final_cnt - f0);
      end
    end
    checks++;
    if (oob_cnt != 0) begin errors++; $display("[TB] FAIL round_range: got %0d out-of-range cycles expected 0", oob_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
    test_reset;
    test_fips_encrypt;
    test_decrypt;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    test_key_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the AES-128 iterative round datapath. It accepts a key/data block over a valid/ready handshake and drives the round index into the combinational key generator. It holds the 128-bit state register, feeds the external round datapath one round per cycle with the correct round-type flags, and returns the result over a second valid/ready handshake. It sits between the bus-facing wrapper and the round/key-expansion logic in EncDec.

## Interface
- `NR`, default 10: number of cipher rounds after the initial AddRoundKey; fixed at 10 for AES-128.
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  request present
- `in_ready`  out  1  controller can accept (high only in IDLE)
- `in_mode`  in  1  0 = encrypt, 1 = decrypt
- `in_key`  in  128  cipher key
- `in_data`  in  128  plaintext or ciphertext
- `key_out`  out  128  latched key, to key generator `keyIn`
- `round`  out  4  round index, to key generator `round`
- `round_key`  in  128  key generator `roundKey` output (combinational from `key_out`/`round`)
- `rnd_state`  out  128  current state register, to round datapath
- `rnd_mode`  out  1  latched mode, to round datapath
- `rnd_final`  out  1  current round omits (Inv)MixColumns
- `rnd_result`  in  128  round datapath output (combinational, includes AddRoundKey with `round_key`)
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  128  ciphertext or plaintext
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `in_key` into `key_out`, `in_data` into `data_q`, and `in_mode` into `rnd_mode`. Set `round` to 0 (encrypt) or NR (decrypt). Go to INIT.
- INIT: state <= `data_q ^ round_key` (whitening). Step `round` (+1 encrypt, −1 decrypt). Go to RUN.
- RUN: state <= `rnd_result` each cycle.
  - `rnd_final`=1 when `round`==NR (encrypt) or `round`==0 (decrypt).
  - On the final round go to DONE and hold `round`; otherwise step `round`.
- DONE: `out_valid`=1 and `out_data`=state. On `out_ready`, go to IDLE. `out_data` stays stable while stalled.
- `round` never leaves 0..NR. Values 11–15 are unreachable and must never be driven.
- A new request is not accepted in the same cycle the previous result is consumed; IDLE is always visited. `in_ready` is a pure function of state, with no combinational path from `out_ready`.
- Reset (any state, including mid-RUN) returns to IDLE and discards the in-flight block without producing output. Reset values:
  - `in_ready`=0 during the reset cycle, then 1.
  - `out_valid`=0, `busy`=0, `rnd_final`=0, `round`=0.
  - `key_out`=0, state=0, `out_data`=0, `rnd_mode`=0.

## Timing
- Accept at cycle T (handshake sampled). INIT at T+1. RUN at T+2..T+11 (10 rounds). `out_valid` high from T+12.
- Throughput: one block per 13 cycles with `out_ready` held high (accept, INIT, 10× RUN, DONE).
- `round_key` and `rnd_result` are combinational and must settle within one cycle. The controller registers nothing on these paths other than the state register.
- All outputs are registered or decoded from registered state only.

## Structure
- Shared package `aes_pkg`:
  - constants `AES_NR`=10 and `AES_BLK_W`=128
  - FSM state enum `aes_ctrl_state_t`
  - mode encodings `AES_ENC`/`AES_DEC`
- One natural sub-module, `aes_round_cnt`: up/down 4-bit round counter with load, step and terminal-detect (`is_last`) outputs. The FSM stays in `aes_round_ctrl`.
- The round datapath and key generator are external. The top-level cipher instantiates all three.

## Test plan
- FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 0, bench reference round model → `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rising exactly 12 cycles after accept.
- Decrypt of the same vector (mode 1, data 69c4…c55a) → 00112233…eeff. `round` sequence observed: 10,9,…,1,0. `rnd_final` high only at `round`=0.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE → `out_valid` and `out_data` stable and `in_ready`=0 throughout. Then complete on `out_ready` and return to IDLE.
- Back-to-back: `in_valid` held high with three vectors and `out_ready`=1 → three correct results spaced 13 cycles apart. No accept occurs while `busy`=1.
- Reset asserted at RUN round 5 → next cycle in IDLE with all outputs at reset values and no `out_valid`. A following request completes correctly.
- Encrypt key sweep: 100 random key/data pairs checked against the reference model. `round` is never above 10, and `rnd_final` is asserted exactly once per block.
